// File: rtl/i_cache_miss_ctrl_if.sv
// Refill bus bundle for the instruction-cache miss controller.
// master = controller side, slave = cache/memory side.
interface i_cache_miss_ctrl_if #(
  parameter int LINE_BITS = 128
);
  logic                 miss_valid;
  logic [31:0]          miss_addr;
  logic                 flush;
  logic                 mem_req_valid;
  logic [31:0]          mem_req_addr;
  logic                 mem_req_ready;
  logic                 mem_rsp_valid;
  logic [31:0]          mem_rsp_addr;
  logic [LINE_BITS-1:0] mem_rsp_data;
  logic                 fill_valid;
  logic [31:0]          fill_addr;
  logic [LINE_BITS-1:0] fill_data;
  logic                 busy;

  modport master (
    input  miss_valid, miss_addr, flush,
    input  mem_req_ready,
    input  mem_rsp_valid, mem_rsp_addr, mem_rsp_data,
    output mem_req_valid, mem_req_addr,
    output fill_valid, fill_addr, fill_data,
    output busy
  );

  modport slave (
    output miss_valid, miss_addr, flush,
    output mem_req_ready,
    output mem_rsp_valid, mem_rsp_addr, mem_rsp_data,
    input  mem_req_valid, mem_req_addr,
    input  fill_valid, fill_addr, fill_data,
    input  busy
  );
endinterface

// File: rtl/i_cache_miss_ctrl.sv
// I-cache miss controller: request, wait (with reissue), fill.
// Optional next-line prefetch: define I_CACHE_NEXT_LINE_PREFETCH_EN.
module i_cache_miss_ctrl #(
  parameter int LINE_BITS   = 128,
  parameter int RSP_TIMEOUT = 64
) (
  input logic clk,
  input logic rst,
  i_cache_miss_ctrl_if.master bus
);

`ifdef I_CACHE_NEXT_LINE_PREFETCH_EN
  typedef enum logic [2:0] {
    IDLE, REQ, WAIT, FILL, PF_REQ, PF_WAIT
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE, REQ, WAIT, FILL
  } state_t;
`endif

  localparam logic [7:0] TO_LAST = 8'(RSP_TIMEOUT - 1);

  state_t               r_state;
  state_t               w_next;
  logic [27:0]          r_line;
  logic [LINE_BITS-1:0] r_data;
  logic [7:0]           r_cnt;
  logic                 r_drop;

  logic w_req_st;
  logic w_wait_st;
  logic w_rsp_hit;
  logic w_timeout;
  logic w_unused;

  // low address bits carry no line information
  assign w_unused = ^{bus.miss_addr[3:0], bus.mem_rsp_addr[3:0]};

`ifdef I_CACHE_NEXT_LINE_PREFETCH_EN
  logic                 r_pf_vld;
  logic [27:0]          r_pf_line;
  logic [LINE_BITS-1:0] r_pf_data;
  logic                 w_pf_hit;

  assign w_req_st  = (r_state == REQ) || (r_state == PF_REQ);
  assign w_wait_st = (r_state == WAIT) || (r_state == PF_WAIT);
  assign w_pf_hit  = r_pf_vld &&
                     (bus.miss_addr[31:4] == r_pf_line);
`else
  assign w_req_st  = (r_state == REQ);
  assign w_wait_st = (r_state == WAIT);
`endif

  // a stale response after a flush is swallowed by r_drop
  assign w_rsp_hit = bus.mem_rsp_valid && !r_drop &&
                     (bus.mem_rsp_addr[31:4] == r_line);
  assign w_timeout = (r_cnt == TO_LAST);

  // next-state decode; flush overrides everything
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (bus.miss_valid) begin
`ifdef I_CACHE_NEXT_LINE_PREFETCH_EN
          w_next = w_pf_hit ? FILL : REQ;
`else
          w_next = REQ;
`endif
        end
      end
      REQ: begin
        if (bus.mem_req_ready) w_next = WAIT;
      end
      WAIT: begin
        if (w_rsp_hit)      w_next = FILL;
        else if (w_timeout) w_next = REQ;
      end
`ifdef I_CACHE_NEXT_LINE_PREFETCH_EN
      FILL:    w_next = PF_REQ;
      PF_REQ: begin
        if (bus.mem_req_ready) w_next = PF_WAIT;
      end
      PF_WAIT: begin
        if (w_rsp_hit)      w_next = IDLE;
        else if (w_timeout) w_next = PF_REQ;
      end
`else
      FILL:    w_next = IDLE;
`endif
      default: w_next = IDLE;
    endcase
    if (bus.flush) w_next = IDLE;
  end

  // state, wait counter, drop flag, line address and fill data
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_line  <= '0;
      r_data  <= '0;
      r_cnt   <= '0;
      r_drop  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_wait_st ? r_cnt + 8'd1 : 8'd0;
      if (bus.flush)
        r_drop <= w_wait_st | (r_drop & ~bus.mem_rsp_valid);
      else if (bus.mem_rsp_valid)
        r_drop <= 1'b0;
      if (!bus.flush) begin
        if (r_state == IDLE && bus.miss_valid)
          r_line <= bus.miss_addr[31:4];
        if (r_state == WAIT && w_rsp_hit)
          r_data <= bus.mem_rsp_data;
`ifdef I_CACHE_NEXT_LINE_PREFETCH_EN
        if (r_state == IDLE && bus.miss_valid && w_pf_hit)
          r_data <= r_pf_data;
        if (r_state == FILL)
          r_line <= r_line + 28'd1;
`endif
      end
    end
  end

`ifdef I_CACHE_NEXT_LINE_PREFETCH_EN
  // one-entry next-line buffer
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pf_vld  <= 1'b0;
      r_pf_line <= '0;
      r_pf_data <= '0;
    end else if (bus.flush) begin
      r_pf_vld <= 1'b0;
    end else if (r_state == PF_WAIT && w_rsp_hit) begin
      r_pf_vld  <= 1'b1;
      r_pf_line <= r_line;
      r_pf_data <= bus.mem_rsp_data;
    end else if (r_state == IDLE && bus.miss_valid && w_pf_hit) begin
      r_pf_vld <= 1'b0;
    end
  end
`endif

  assign bus.mem_req_valid = w_req_st & ~bus.flush;
  assign bus.mem_req_addr  = {r_line, 4'h0};
  assign bus.fill_valid    = (r_state == FILL) & ~bus.flush;
  assign bus.fill_addr     = {r_line, 4'h0};
  assign bus.fill_data     = r_data;
  assign bus.busy          = (r_state != IDLE);

endmodule

// File: tb/tb_i_cache_miss_ctrl.sv
// Directed bench for i_cache_miss_ctrl.
// Prefetch scenarios run when I_CACHE_NEXT_LINE_PREFETCH_EN is defined.
module tb_i_cache_miss_ctrl;

  logic clk = 1'b0;
  logic rst;

  int n_checks = 0;
  int n_err    = 0;
  int fills    = 0;
  int reqs     = 0;
  int f0;
  int r0;

  localparam logic [127:0] D1 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [127:0] D2 = 128'h2222_2222_2222_2222_2222_2222_2222_2222;
  localparam logic [127:0] D3 = 128'h3333_0000_3333_0000_3333_0000_3333_0003;
  localparam logic [127:0] D4 = 128'h4444_4444_0000_0000_4444_4444_0000_0004;
  localparam logic [127:0] D5 = 128'h5555_5555_5555_5555_AAAA_AAAA_AAAA_AAAA;
  localparam logic [127:0] D6 = 128'hDEAD_DEAD_DEAD_DEAD_DEAD_DEAD_DEAD_DEAD;
  localparam logic [127:0] D7 = 128'h7777_0000_0000_0000_0000_0000_0000_7777;

  i_cache_miss_ctrl_if #(.LINE_BITS(128)) bus ();

  i_cache_miss_ctrl #(
    .LINE_BITS  (128),
    .RSP_TIMEOUT(64)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // count fill pulses and accepted requests
  always @(negedge clk) begin
    if (bus.fill_valid) fills++;
    if (bus.mem_req_valid && bus.mem_req_ready) reqs++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rsp(input logic [31:0] a, input logic [127:0] d);
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_addr  = a;
    bus.mem_rsp_data  = d;
    tick();
    bus.mem_rsp_valid = 1'b0;
    settle();
  endtask

  task automatic miss_to_wait(input logic [31:0] a);
    bus.miss_valid    = 1'b1;
    bus.miss_addr     = a;
    bus.mem_req_ready = 1'b1;
    tick();
    tick();
    settle();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_reqv"}, 128'(bus.mem_req_valid), 128'd0);
    chk({tag, "_fillv"}, 128'(bus.fill_valid), 128'd0);
    chk({tag, "_busy"}, 128'(bus.busy), 128'd0);
    chk({tag, "_reqa"}, 128'(bus.mem_req_addr), 128'd0);
    chk({tag, "_filla"}, 128'(bus.fill_addr), 128'd0);
    chk({tag, "_filld"}, bus.fill_data, 128'd0);
  endtask

  initial begin
    rst               = 1'b1;
    bus.miss_valid    = 1'b1;
    bus.miss_addr     = 32'h0000_1234;
    bus.flush         = 1'b1;
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_addr  = '0;
    bus.mem_rsp_data  = '0;
    tick();
    tick();
    settle();
    chk_zero("reset");

    rst            = 1'b0;
    bus.miss_valid = 1'b0;
    bus.flush      = 1'b0;
    tick();

`ifdef I_CACHE_NEXT_LINE_PREFETCH_EN
    // demand miss on 0x1000, then next-line prefetch of 0x1010
    f0 = fills;
    miss_to_wait(32'h0000_1000);
    rsp(32'h0000_1000, D1);
    chk("pf_fill_v", 128'(bus.fill_valid), 128'd1);
    chk("pf_fill_a", 128'(bus.fill_addr), 128'h1000);
    chk("pf_fill_d", bus.fill_data, D1);
    bus.miss_valid = 1'b0;
    tick();
    settle();
    chk("pf_req_v", 128'(bus.mem_req_valid), 128'd1);
    chk("pf_req_a", 128'(bus.mem_req_addr), 128'h1010);
    chk("pf_req_nofill", 128'(bus.fill_valid), 128'd0);
    tick();
    settle();
    rsp(32'h0000_1010, D2);
    chk("pf_stored_idle", 128'(bus.busy), 128'd0);
    chk("pf_one_fill", 128'(fills - f0), 128'd1);

    // buffer hit: fill next cycle, no memory request
    r0 = reqs;
    bus.miss_valid = 1'b1;
    bus.miss_addr  = 32'h0000_1014;
    tick();
    settle();
    chk("pfhit_fill_v", 128'(bus.fill_valid), 128'd1);
    chk("pfhit_fill_a", 128'(bus.fill_addr), 128'h1010);
    chk("pfhit_fill_d", bus.fill_data, D2);
    chk("pfhit_noreq", 128'(reqs - r0), 128'd0);
    bus.miss_valid = 1'b0;
    tick();
    bus.flush = 1'b1;
    settle();
    chk("pf_flush_reqv", 128'(bus.mem_req_valid), 128'd0);
    tick();
    bus.flush = 1'b0;
    settle();
    chk("pf_flush_idle", 128'(bus.busy), 128'd0);

    // wraparound of the prefetch address
    miss_to_wait(32'hFFFF_FFF4);
    rsp(32'hFFFF_FFF0, D3);
    chk("wrap_fill_a", 128'(bus.fill_addr), 128'hFFFF_FFF0);
    bus.miss_valid = 1'b0;
    tick();
    settle();
    chk("wrap_req_v", 128'(bus.mem_req_valid), 128'd1);
    chk("wrap_req_a", 128'(bus.mem_req_addr), 128'h0);
    tick();
    settle();
    chk("wrap_pfwait_busy", 128'(bus.busy), 128'd1);
    rst = 1'b1;
    tick();
    settle();
    chk_zero("midwait_rst");
    rst = 1'b0;
    tick();
`else
    // basic miss, response after 5 WAIT cycles
    f0 = fills;
    r0 = reqs;
    bus.miss_valid    = 1'b1;
    bus.miss_addr     = 32'h0000_BEEF;
    bus.mem_req_ready = 1'b1;
    settle();
    chk("m1_idle_busy", 128'(bus.busy), 128'd0);
    tick();
    settle();
    chk("m1_req_v", 128'(bus.mem_req_valid), 128'd1);
    chk("m1_req_a", 128'(bus.mem_req_addr), 128'hBEE0);
    chk("m1_busy", 128'(bus.busy), 128'd1);
    tick();
    settle();
    chk("m1_wait_reqv", 128'(bus.mem_req_valid), 128'd0);
    for (int i = 0; i < 5; i++) tick();
    rsp(32'h0000_BEE0, D1);
    chk("m1_fill_v", 128'(bus.fill_valid), 128'd1);
    chk("m1_fill_a", 128'(bus.fill_addr), 128'hBEE0);
    chk("m1_fill_d", bus.fill_data, D1);
    bus.miss_valid = 1'b0;
    tick();
    settle();
    chk("m1_fill_1cyc", 128'(bus.fill_valid), 128'd0);
    chk("m1_idle", 128'(bus.busy), 128'd0);
    chk("m1_fills", 128'(fills - f0), 128'd1);
    chk("m1_reqs", 128'(reqs - r0), 128'd1);

    // mismatched response dropped, matching one fills
    miss_to_wait(32'h0000_0100);
    rsp(32'h0000_0200, D2);
    chk("mm_still_wait", 128'(bus.busy), 128'd1);
    chk("mm_no_fill", 128'(bus.fill_valid), 128'd0);
    rsp(32'h0000_0100, D3);
    chk("mm_fill_a", 128'(bus.fill_addr), 128'h100);
    chk("mm_fill_d", bus.fill_data, D3);

    // back-to-back miss after FILL, held request, flush in REQ
    bus.miss_addr     = 32'h0000_0500;
    bus.mem_req_ready = 1'b0;
    tick();
    tick();
    settle();
    chk("b2b_req_a", 128'(bus.mem_req_addr), 128'h500);
    tick();
    settle();
    chk("hold_req_v", 128'(bus.mem_req_valid), 128'd1);
    chk("hold_req_a", 128'(bus.mem_req_addr), 128'h500);
    r0 = reqs;
    bus.flush         = 1'b1;
    bus.mem_req_ready = 1'b1;
    settle();
    chk("flreq_reqv", 128'(bus.mem_req_valid), 128'd0);
    tick();
    bus.flush      = 1'b0;
    bus.miss_valid = 1'b0;
    settle();
    chk("flreq_idle", 128'(bus.busy), 128'd0);
    chk("flreq_noreq", 128'(reqs - r0), 128'd0);

    // timeout reissue
    r0 = reqs;
    f0 = fills;
    miss_to_wait(32'h0000_0040);
    for (int i = 0; i < 63; i++) tick();
    settle();
    chk("to_wait_reqv", 128'(bus.mem_req_valid), 128'd0);
    bus.mem_req_ready = 1'b0;
    tick();
    settle();
    chk("to_reissue_v", 128'(bus.mem_req_valid), 128'd1);
    chk("to_reissue_a", 128'(bus.mem_req_addr), 128'h40);
    bus.mem_req_ready = 1'b1;
    tick();
    settle();
    chk("to_reqs", 128'(reqs - r0), 128'd2);
    rsp(32'h0000_0040, D4);
    chk("to_fill_d", bus.fill_data, D4);
    bus.miss_valid = 1'b0;
    tick();
    settle();
    chk("to_fills", 128'(fills - f0), 128'd1);

    // flush in WAIT, stale response, then miss 0xC0
    f0 = fills;
    miss_to_wait(32'h0000_0080);
    bus.flush = 1'b1;
    tick();
    bus.flush      = 1'b0;
    bus.miss_valid = 1'b0;
    settle();
    chk("fl_idle", 128'(bus.busy), 128'd0);
    rsp(32'h0000_0080, D6);
    chk("fl_stale_nofill", 128'(bus.fill_valid), 128'd0);
    miss_to_wait(32'h0000_00C0);
    rsp(32'h0000_00C0, D5);
    chk("fl_c0_fill_a", 128'(bus.fill_addr), 128'hC0);
    chk("fl_c0_fill_d", bus.fill_data, D5);
    bus.miss_valid = 1'b0;
    tick();
    settle();
    chk("fl_fills", 128'(fills - f0), 128'd1);

    // stale response matching a re-missed line is still dropped
    miss_to_wait(32'h0000_0080);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    tick();
    tick();
    settle();
    rsp(32'h0000_0080, D6);
    chk("drop_no_fill", 128'(bus.fill_valid), 128'd0);
    chk("drop_busy", 128'(bus.busy), 128'd1);
    rsp(32'h0000_0080, D7);
    chk("drop_fill_d", bus.fill_data, D7);
    bus.flush = 1'b1;
    settle();
    chk("flfill_fillv", 128'(bus.fill_valid), 128'd0);
    tick();
    bus.flush      = 1'b0;
    bus.miss_valid = 1'b0;
    settle();
    chk("flfill_idle", 128'(bus.busy), 128'd0);

    // reset in WAIT wins over a simultaneous flush
    miss_to_wait(32'h0000_0A00);
    rst       = 1'b1;
    bus.flush = 1'b1;
    tick();
    settle();
    chk_zero("midwait_rst");
    rst            = 1'b0;
    bus.flush      = 1'b0;
    bus.miss_valid = 1'b0;
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/i_cache_miss_ctrl.md
I_CACHE_MISS_CTRL -- requirements
Module: i_cache_miss_ctrl

Interface
REQ-001 The block SHALL have one clock and one synchronous active-high reset.
REQ-002 Parameter LINE_BITS, 128, refill line width (4 x 32-bit instructions).
REQ-003 Parameter RSP_TIMEOUT, 64, WAIT cycles before a request is reissued (range 2..255).
REQ-004 Ports SHALL be:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- miss_valid  in  1  cache reports a miss; held high until fill_valid.
- miss_addr  in  32  missing PC; held stable while miss_valid.
- flush  in  1  abort all refill activity (branch redirect).
- mem_req_valid  out  1  request to instruction memory.
- mem_req_addr  out  32  line-aligned request address, bits[3:0]=0.
- mem_req_ready  in  1  memory accepts the request this cycle.
- mem_rsp_valid  in  1  memory response valid (one cycle).
- mem_rsp_addr  in  32  line address of the response.
- mem_rsp_data  in  LINE_BITS  returned line.
- fill_valid  out  1  one-cycle line write into the cache.
- fill_addr  out  32  line-aligned fill address.
- fill_data  out  LINE_BITS  fill line.
- busy  out  1  FSM not in IDLE.

Function
REQ-005 The FSM SHALL have states IDLE, REQ, WAIT and FILL.
REQ-006 IDLE->REQ when miss_valid=1; the request address SHALL be latched as {miss_addr[31:4],4'h0}.
REQ-007 In REQ, mem_req_valid=1 with the latched address; REQ->WAIT when mem_req_ready=1 in the same cycle.
REQ-008 In WAIT, a response SHALL be accepted only if mem_rsp_valid=1 and mem_rsp_addr[31:4] equals the latched line; the data SHALL be registered and the FSM SHALL go to FILL.
REQ-009 A response in WAIT with a mismatched address SHALL be dropped without any state change.
REQ-010 FILL SHALL drive fill_valid=1 for exactly one cycle, then go to IDLE; demand-miss latency SHALL be miss_valid to fill_valid = 3 cycles plus memory latency.
REQ-011 An 8-bit wait counter SHALL clear on entry to WAIT and increment each WAIT cycle; when it reaches RSP_TIMEOUT, WAIT->REQ reissues the same address.
REQ-012 flush=1 SHALL force IDLE on the next edge from any state, deassert mem_req_valid and fill_valid in that cycle, and override every simultaneous event.
REQ-013 After a flush with a request outstanding, the first subsequent mem_rsp_valid SHALL be discarded (one-bit drop flag).
REQ-014 A new miss in the cycle after FILL SHALL be accepted normally; miss_valid outside IDLE SHALL be ignored.
REQ-015 fill_addr SHALL always be line-aligned; mem_req_addr SHALL be stable while mem_req_valid=1 and mem_req_ready=0.

Reset
REQ-016 On rst=1 at a clock edge, the block SHALL set: state IDLE; mem_req_valid, fill_valid and busy 0; mem_req_addr, fill_addr and fill_data 0; wait counter, drop flag and prefetch buffer cleared.
REQ-017 Reset SHALL take precedence over flush and over all inputs.

Configuration
REQ-018 Macro I_CACHE_NEXT_LINE_PREFETCH_EN SHALL add the states PF_REQ and PF_WAIT and a one-entry prefetch buffer (valid, line address, data).
REQ-019 With the macro defined, after FILL of line L the FSM SHALL go to PF_REQ, request L+16 (32-bit wraparound: 0xFFFF_FFF0 -> 0x0000_0000), and store the response in the buffer without asserting fill_valid.
REQ-020 With the macro defined, a miss in IDLE that hits the valid buffer SHALL go directly to FILL from buffer data, issue no memory request, and invalidate the buffer.
REQ-021 With the macro defined, a miss during PF_REQ or PF_WAIT SHALL be served after the prefetch completes; flush SHALL invalidate the buffer.
REQ-022 Without the macro, the block SHALL contain no prefetch logic, and FILL SHALL always return to IDLE.

Verification
REQ-023 Miss 0x0000_BEEF, ready=1, response 0x0000_BEE0 after 5 cycles, data D -> mem_req_addr=0x0000_BEE0, one fill_valid with fill_addr=0x0000_BEE0 and fill_data=D.
REQ-024 Miss 0x100, then a response at 0x200 followed by a response at 0x100 -> the first is ignored, and the fill uses 0x100 data.
REQ-025 Miss 0x40, no response for RSP_TIMEOUT cycles -> a second request to 0x40; a response then produces one fill.
REQ-026 Flush during WAIT for 0x80, stale response, then miss 0xC0 -> no fill for 0x80; the stale response is dropped; the fill for 0xC0 is correct.
REQ-027 Prefetch on: miss 0x1000 -> fill 0x1000, then a request to 0x1010; a later miss 0x1014 -> fill within 2 cycles with no memory request.
REQ-028 Prefetch on: miss 0xFFFF_FFF4 -> prefetch request to 0x0000_0000; rst asserted mid-WAIT -> all outputs return to 0 on the next edge.
